traffic_manager: RTL

Parametrised successor to the single-car game logic. Owns NUM_LANES car lanes, each with its own direction and level-scaled speed. Detects frog/car overlap and the win row, and runs the game-state FSM (play, death hold, restart). Sits between the frog controller and the VGA controller: it consumes frog_x and frog_y and a per-frame tick, and drives the packed car coordinates, the frog reset request and the level count.

---
 rtl/frogger_pkg.sv | 37 +++
 rtl/traffic_manager_if.sv | 38 +++
 rtl/traffic_manager_lane_mover.sv | 59 +++++
 rtl/traffic_manager.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the traffic manager slice:
//   - game-state enum (RUN, HIT, RESTART)
//   - default coordinate width, screen and lane geometry, timing constants
//   - start_x(): start column of a lane, wrapped to the screen width
// No ports (package).
// -----------------------------------------------------------------------------
package frogger_pkg;

    localparam int DEF_NUM_LANES     = 4;
    localparam int DEF_COORD_W       = 10;
    localparam int DEF_SCREEN_W      = 640;
    localparam int DEF_LANE_Y0       = 96;
    localparam int DEF_LANE_H        = 32;
    localparam int DEF_CAR_W         = 32;
    localparam int DEF_FROG_W        = 32;
    localparam int DEF_WIN_Y         = 32;
    localparam int DEF_START_SPACING = 160;
    localparam int DEF_MAX_LEVEL     = 9;
    localparam int DEF_HOLD_FRAMES   = 30;
    localparam logic [DEF_NUM_LANES-1:0] DEF_DIR_MASK = 4'b1010;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HIT     = 2'd1,
        ST_RESTART = 2'd2
    } state_e;

    // Start column of lane i; lanes are spread evenly and wrapped onto the screen.
    function automatic int start_x(input int i,
                                   input int spacing  = DEF_START_SPACING,
                                   input int screen_w = DEF_SCREEN_W);
        return (i * spacing) % screen_w;
    endfunction

endpackage

// File: rtl/traffic_manager_if.sv
// -----------------------------------------------------------------------------
// traffic_manager_if
// Bundles the frog/VGA-facing signals of the traffic manager.
//   frame_tick    : one-cycle pulse per video frame         (master -> slave)
//   force_restart : player restart request                  (master -> slave)
//   frog_x/frog_y : frog left/top edge                      (master -> slave)
//   car_x/car_y   : packed car coordinates, lane i at [i*COORD_W +: COORD_W]
//   frog_reset    : one-cycle pulse, frog back to start     (slave -> master)
//   death / win   : one-cycle event pulses                  (slave -> master)
//   level         : current level                           (slave -> master)
// Modports: master (frog controller / VGA side), slave (traffic_manager).
// -----------------------------------------------------------------------------
interface traffic_manager_if #(
    parameter int NUM_LANES = 4,
    parameter int COORD_W   = 10,
    parameter int LVL_W     = 4
);
    logic                         frame_tick;
    logic                         force_restart;
    logic [COORD_W-1:0]           frog_x;
    logic [COORD_W-1:0]           frog_y;
    logic [NUM_LANES*COORD_W-1:0] car_x;
    logic [NUM_LANES*COORD_W-1:0] car_y;
    logic                         frog_reset;
    logic                         death;
    logic                         win;
    logic [LVL_W-1:0]             level;

    modport master (
        output frame_tick, force_restart, frog_x, frog_y,
        input  car_x, car_y, frog_reset, death, win, level
    );

    modport slave (
        input  frame_tick, force_restart, frog_x, frog_y,
        output car_x, car_y, frog_reset, death, win, level
    );
endinterface

// File: rtl/traffic_manager_lane_mover.sv
// -----------------------------------------------------------------------------
// lane_mover
// Horizontal position register of one car lane with wrap-around movement.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (loads START_X)
//   dir_left_i  : 1 = lane moves left, 0 = right
//   step_i      : pixels moved per tick
//   tick_i      : frame tick
//   freeze_i    : hold position even if tick_i is high
//   reload_i    : load START_X (wins over movement)
//   x_o         : current left edge of the car
// Arithmetic is one bit wider than the coordinate so x+step never overflows
// before the wrap compare.
// -----------------------------------------------------------------------------
module lane_mover #(
    parameter int                 COORD_W  = 10,
    parameter int                 SCREEN_W = 640,
    parameter logic [COORD_W-1:0] START_X  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dir_left_i,
    input  logic [COORD_W-1:0] step_i,
    input  logic               tick_i,
    input  logic               freeze_i,
    input  logic               reload_i,
    output logic [COORD_W-1:0] x_o
);
    localparam logic [COORD_W:0] SCREEN_W_EXT = (COORD_W+1)'(SCREEN_W);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W:0]   x_ext, step_ext, sum_ext, right_ext, left_ext;

    always_comb begin
        x_ext     = {1'b0, x_q};
        step_ext  = {1'b0, step_i};
        sum_ext   = x_ext + step_ext;
        right_ext = (sum_ext >= SCREEN_W_EXT) ? (sum_ext - SCREEN_W_EXT) : sum_ext;
        // Going below zero re-enters from the right edge.
        left_ext  = (x_ext < step_ext) ? (x_ext + SCREEN_W_EXT - step_ext)
                                       : (x_ext - step_ext);
        x_d = x_q;
        if (reload_i) begin
            x_d = START_X;
        end else if (tick_i && !freeze_i) begin
            x_d = dir_left_i ? COORD_W'(left_ext) : COORD_W'(right_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= START_X;
        end else begin
            x_q <= x_d;
        end
    end

    assign x_o = x_q;
endmodule

// File: rtl/traffic_manager.sv
// -----------------------------------------------------------------------------
// traffic_manager
// Multi-lane car traffic and game-state control for the frog game.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : traffic_manager_if.slave (frame_tick, force_restart, frog_x,
//            frog_y in; car_x, car_y, frog_reset, death, win, level out)
// Game FSM: RUN (cars move on frame_tick), HIT (cars frozen for HOLD_FRAMES
// frame ticks after a death), RESTART (one cycle, cars reload start columns).
// Event priority: reset > force_restart > death > win > movement.
// Optional feature macro LEVEL_SPEED_EN: when defined, every lane's step also
// includes the current level; otherwise the step depends only on lane parity.
// -----------------------------------------------------------------------------
module traffic_manager
    import frogger_pkg::*;
#(
    parameter int                     NUM_LANES     = DEF_NUM_LANES,
    parameter int                     COORD_W       = DEF_COORD_W,
    parameter int                     SCREEN_W      = DEF_SCREEN_W,
    parameter int                     LANE_Y0       = DEF_LANE_Y0,
    parameter int                     LANE_H        = DEF_LANE_H,
    parameter int                     CAR_W         = DEF_CAR_W,
    parameter int                     FROG_W        = DEF_FROG_W,
    parameter int                     WIN_Y         = DEF_WIN_Y,
    parameter int                     START_SPACING = DEF_START_SPACING,
    parameter logic [NUM_LANES-1:0]   DIR_MASK      = DEF_DIR_MASK,
    parameter int                     MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int                     HOLD_FRAMES   = DEF_HOLD_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    traffic_manager_if.slave   bus
);
    localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [COORD_W:0]   CAR_W_EXT  = (COORD_W+1)'(CAR_W);
    localparam logic [COORD_W:0]   FROG_W_EXT = (COORD_W+1)'(FROG_W);
    localparam logic [COORD_W:0]   LANE_H_EXT = (COORD_W+1)'(LANE_H);
    localparam logic [COORD_W-1:0] WIN_Y_C    = COORD_W'(WIN_Y);
    localparam logic [LVL_W-1:0]   LEVEL_TOP  = LVL_W'(MAX_LEVEL);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                death_q, death_d;
    logic                win_q, win_d;
    logic                frog_reset_q, frog_reset_d;
    logic                move_ok;

    wire  [COORD_W-1:0]  car_x_w [NUM_LANES];
    wire  [NUM_LANES-1:0] hit_w;
    wire  [COORD_W:0]    fx_ext = {1'b0, bus.frog_x};
    wire  [COORD_W:0]    fy_ext = {1'b0, bus.frog_y};
    wire                 any_hit = |hit_w;
    wire                 at_win  = (bus.frog_y <= WIN_Y_C);
    wire                 reload_w = (state_q == ST_RESTART);
    wire                 freeze_w = !move_ok;

    logic [NUM_LANES*COORD_W-1:0] car_x_pack, car_y_pack;

    // ------------------------------------------------------------------
    // Lanes: position register, step and overlap test per lane
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [COORD_W-1:0] START_X =
                COORD_W'(start_x(gi, START_SPACING, SCREEN_W));
            localparam logic [COORD_W:0]   CAR_Y =
                (COORD_W+1)'(LANE_Y0 + gi * LANE_H);
            localparam logic [COORD_W-1:0] BASE_STEP = COORD_W'(1 + (gi % 2));

            wire [COORD_W-1:0] step_w;
`ifdef LEVEL_SPEED_EN
            assign step_w = BASE_STEP + COORD_W'(level_q);
`else
            assign step_w = BASE_STEP;
`endif

            lane_mover #(
                .COORD_W  (COORD_W),
                .SCREEN_W (SCREEN_W),
                .START_X  (START_X)
            ) u_lane (
                .clk        (clk),
                .reset      (reset),
                .dir_left_i (DIR_MASK[gi]),
                .step_i     (step_w),
                .tick_i     (bus.frame_tick),
                .freeze_i   (freeze_w),
                .reload_i   (reload_w),
                .x_o        (car_x_w[gi])
            );

            // Plain rectangle test at the stored x; a car straddling the
            // wrap edge is not tested at its wrapped-around part.
            wire [COORD_W:0] cx_ext = {1'b0, car_x_w[gi]};
            assign hit_w[gi] = (fx_ext < cx_ext + CAR_W_EXT) &&
                               (cx_ext < fx_ext + FROG_W_EXT) &&
                               (fy_ext < CAR_Y + LANE_H_EXT) &&
                               (CAR_Y  < fy_ext + FROG_W_EXT);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Game FSM: next state and registered event pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        level_d      = level_q;
        death_d      = 1'b0;
        win_d        = 1'b0;
        frog_reset_d = 1'b0;
        move_ok      = 1'b0;

        if (bus.force_restart) begin
            state_d      = ST_RESTART;
            frog_reset_d = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (any_hit) begin
                        // Death discards any move requested this cycle.
                        state_d      = ST_HIT;
                        death_d      = 1'b1;
                        frog_reset_d = 1'b1;
                        hold_d       = '0;
                    end else if (at_win) begin
                        win_d        = 1'b1;
                        frog_reset_d = 1'b1;
                        level_d      = (level_q == LEVEL_TOP) ? '0
                                                              : level_q + LVL_W'(1);
                    end else begin
                        move_ok = 1'b1;
                    end
                end
                ST_HIT: begin
                    if (bus.frame_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_RESTART;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_RESTART: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            hold_q       <= '0;
            level_q      <= '0;
            death_q      <= 1'b0;
            win_q        <= 1'b0;
            frog_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            level_q      <= level_d;
            death_q      <= death_d;
            win_q        <= win_d;
            frog_reset_q <= frog_reset_d;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    always_comb begin
        car_x_pack = '0;
        car_y_pack = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            car_x_pack[i*COORD_W +: COORD_W] = car_x_w[i];
            car_y_pack[i*COORD_W +: COORD_W] = COORD_W'(LANE_Y0 + i * LANE_H);
        end
    end

    assign bus.car_x      = car_x_pack;
    assign bus.car_y      = car_y_pack;
    assign bus.death      = death_q;
    assign bus.win        = win_q;
    assign bus.frog_reset = frog_reset_q;
    assign bus.level      = level_q;
endmodule
